// File: rtl/serial_add_sub.sv
// serial_add_sub
//   Bit-serial adder/subtractor: one full-adder cell plus a carry flop, one
//   operand bit per clock, LSB first. A WIDTH-bit operation takes WIDTH+1
//   clocks from start to done. Subtraction is a + ~b + 1, so in sub mode
//   cout=1 means "no borrow".
//
//   Ports
//     clk       rising-edge clock
//     rst       asynchronous, active-high reset
//     start     request, honoured only in IDLE or DONE
//     a, b      operands, captured on the accept edge
//     cin       carry-in (add mode only), captured on the accept edge
//     sub       0: a+b+cin, 1: a-b, captured on the accept edge
//     busy      high while the serial operation runs
//     done      one-cycle completion pulse
//     sum       result modulo 2^WIDTH, held until the next completion
//     cout      carry out of the MSB
//     overflow  signed overflow (carry into MSB ^ carry out of MSB)
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | waiting for start
//   RUN   | one operand bit consumed per clock
//   DONE  | result valid; start here is accepted directly
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             bit_s;
  logic             bit_c;
  logic             last_bit;

  // Full-adder cell on the current LSBs.
  assign bit_s    = opa[0] ^ opb[0] ^ carry;
  assign bit_c    = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
  assign last_bit = (cnt == LAST);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      opa   <= {1'b0, opa[WIDTH-1:1]};
      opb   <= {1'b0, opb[WIDTH-1:1]};
      res   <= {bit_s, res[WIDTH-1:1]};
      carry <= bit_c;
      cnt   <= cnt + 1'b1;
      if (last_bit) begin
        // Publish only the complete result; carry here is the carry into the MSB.
        sum      <= {bit_s, res[WIDTH-1:1]};
        cout     <= bit_c;
        overflow <= carry ^ bit_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       overflow;

  logic       start3;
  logic [2:0] a3;
  logic [2:0] b3;
  logic       cin3;
  logic       sub3;
  logic       busy3;
  logic       done3;
  logic [2:0] sum3;
  logic       cout3;
  logic       overflow3;

  int total;
  int bad;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  serial_add_sub #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3), .sub(sub3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .overflow(overflow3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation on the 8-bit instance and waits (bounded) for done.
  // lat counts rising edges from the accept edge through the edge raising done.
  task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib,
                        input logic icin, input logic isub,
                        output int lat, output logic ok);
    @(negedge clk);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ia; b = ~ib; cin = ~icin; sub = ~isub;
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0; sub3 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, sum, cout, overflow} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b sum=%0d cout=%b ov=%b want all 0",
               busy, done, sum, cout, overflow);
    end
    total++;
    if ({busy3, done3, sum3, cout3, overflow3} !== 6'd0) begin
      bad++;
      $display("FAIL reset_outputs_w3 got busy=%b done=%b sum=%0d want all 0", busy3, done3, sum3);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_basic();
    int lat; logic ok;
    do_op8(8'd100, 8'd55, 1'b0, 1'b0, lat, ok);
    total++;
    if (!ok || lat != 9) begin
      bad++;
      $display("FAIL add_latency got ok=%b lat=%0d want lat=9", ok, lat);
    end
    total++;
    if ({sum, cout, overflow} !== {8'd155, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL add_100_55 got sum=%0d cout=%b ov=%b want 155 0 1", sum, cout, overflow);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_single_pulse got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_wrap();
    int lat; logic ok;
    do_op8(8'd255, 8'd1, 1'b0, 1'b0, lat, ok);
    total++;
    if (!ok || {sum, cout, overflow} !== {8'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL add_255_1 got ok=%b sum=%0d cout=%b ov=%b want 0 1 0", ok, sum, cout, overflow);
    end
    do_op8(8'd127, 8'd0, 1'b1, 1'b0, lat, ok);
    total++;
    if (!ok || {sum, cout, overflow} !== {8'd128, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL add_127_0_cin got ok=%b sum=%0d cout=%b ov=%b want 128 0 1", ok, sum, cout, overflow);
    end
  endtask

  task automatic test_subtract();
    int lat; logic ok;
    // cin=1 here must be ignored in sub mode.
    do_op8(8'd5, 8'd3, 1'b1, 1'b1, lat, ok);
    total++;
    if (!ok || {sum, cout, overflow} !== {8'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sub_5_3 got ok=%b sum=%0d cout=%b ov=%b want 2 1 0", ok, sum, cout, overflow);
    end
    do_op8(8'd3, 8'd5, 1'b0, 1'b1, lat, ok);
    total++;
    if (!ok || {sum, cout, overflow} !== {8'd254, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL sub_3_5 got ok=%b sum=%0d cout=%b ov=%b want 254 0 0", ok, sum, cout, overflow);
    end
    do_op8(8'd128, 8'd1, 1'b0, 1'b1, lat, ok);
    total++;
    if (!ok || {sum, cout, overflow} !== {8'd127, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL sub_128_1 got ok=%b sum=%0d cout=%b ov=%b want 127 1 1", ok, sum, cout, overflow);
    end
  endtask

  task automatic test_start_in_run();
    int lat; logic ok;
    @(negedge clk);
    a = 8'd20; b = 8'd30; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd200; b = 8'd100; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    total++;
    if (!ok || lat != 9 || sum !== 8'd50 || cout !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL start_in_run got ok=%b lat=%0d sum=%0d cout=%b ov=%b want lat=9 50 0 0",
               ok, lat, sum, cout, overflow);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL no_queued_start got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic ok;
    do_op8(8'd10, 8'd20, 1'b1, 1'b0, lat, ok);
    total++;
    if (!ok || sum !== 8'd31) begin
      bad++;
      $display("FAIL b2b_first got ok=%b sum=%0d want 31", ok, sum);
    end
    // Still in the DONE cycle: start here is accepted on the next edge.
    a = 8'd50; b = 8'd60; cin = 1'b0; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done);
    end
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    total++;
    if (!ok || lat != 9 || {sum, cout, overflow} !== {8'd246, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL b2b_second got ok=%b lat=%0d sum=%0d cout=%b ov=%b want lat=9 246 0 0",
               ok, lat, sum, cout, overflow);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic ok; logic saw_done;
    do_op8(8'd128, 8'd255, 1'b0, 1'b0, lat, ok);
    total++;
    if (!ok || {sum, cout, overflow} !== {8'd127, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL pre_reset_op got ok=%b sum=%0d cout=%b ov=%b want 127 1 1", ok, sum, cout, overflow);
    end
    @(negedge clk);
    a = 8'd1; b = 8'd2; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, sum, cout, overflow} !== 11'd0) begin
      bad++;
      $display("FAIL reset_mid_run got busy=%b done=%b sum=%0d cout=%b ov=%b want all 0",
               busy, done, sum, cout, overflow);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b0;
      if (done) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_done got saw_done=%b want 0", saw_done);
    end
    do_op8(8'd100, 8'd55, 1'b0, 1'b0, lat, ok);
    total++;
    if (!ok || lat != 9 || {sum, cout, overflow} !== {8'd155, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL after_reset_op got ok=%b lat=%0d sum=%0d cout=%b ov=%b want lat=9 155 0 1",
               ok, lat, sum, cout, overflow);
    end
  endtask

  task automatic test_exhaustive_w3();
    int sa, sb, r, ures;
    logic [2:0] esum;
    logic ecout, eov, ok;
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int ia = 0; ia < 8; ia++) begin
          for (int ib = 0; ib < 8; ib++) begin
            sa = (ia >= 4) ? ia - 8 : ia;
            sb = (ib >= 4) ? ib - 8 : ib;
            if (s == 0) begin
              ures  = ia + ib + c;
              r     = sa + sb + c;
              ecout = (ures >= 8);
            end else begin
              ures  = ia - ib + 8;
              r     = sa - sb;
              ecout = (ia >= ib);
            end
            esum = 3'(ures % 8);
            eov  = (r > 3) || (r < -4);
            @(negedge clk);
            a3 = 3'(ia); b3 = 3'(ib); cin3 = c[0]; sub3 = s[0]; start3 = 1'b1;
            @(negedge clk);
            start3 = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
              if (done3) begin
                ok = 1'b1;
                break;
              end
              @(negedge clk);
            end
            total++;
            if (!ok || {sum3, cout3, overflow3} !== {esum, ecout, eov}) begin
              bad++;
              $display("FAIL w3 a=%0d b=%0d cin=%0d sub=%0d got ok=%b sum=%0d cout=%b ov=%b want %0d %b %b",
                       ia, ib, c, s, ok, sum3, cout3, overflow3, esum, ecout, eov);
            end
          end
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add_basic();
    test_wrap();
    test_subtract();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive_w3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
